// File: rtl/cfg_arbiter_pkg.sv
// cfg_arbiter shared types, width defaults and index-width helper.
// Used by cfg_arbiter and arb_rr.
package cfg_arbiter_pkg;

  localparam int CFG_AWIDTH_DEF = 5;
  localparam int CFG_DWIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_WR,
    OP_RD
  } op_e;

  // Bits needed to index n requesters (minimum 1).
  function automatic int idx_w(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/cfg_arbiter_arb_rr.sv
// arb_rr: combinational rotate-priority encoder.
// Picks the first request at or above ptr, wrapping to bit 0.
module arb_rr
  import cfg_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int TW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [TW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [TW-1:0] idx_o,
  output logic          any_o
);

  logic [N-1:0] hi;
  logic [N-1:0] sel;

  always_comb begin
    hi = '0;
    for (int j = 0; j < N; j++) begin
      hi[j] = req_i[j] && (TW'(j) >= ptr_i);
    end
  end

  // Requests at/above ptr win; otherwise wrap to the lowest.
  assign sel   = (|hi) ? hi : req_i;
  assign any_o = |req_i;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (sel[j]) begin
        gnt_o    = '0;
        gnt_o[j] = 1'b1;
        idx_o    = TW'(j);
      end
    end
  end

endmodule

// File: rtl/cfg_arbiter.sv
// cfg_arbiter: round-robin share of the cfg register-bank port.
// Optional CFG_ARB_LOCK_EN adds req_lock for read-modify-write holds.
module cfg_arbiter
  import cfg_arbiter_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int CFG_AWIDTH = CFG_AWIDTH_DEF,
  parameter int CFG_DWIDTH = CFG_DWIDTH_DEF,
  parameter int RD_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_wr_en,
  input  logic [NREQ*CFG_AWIDTH-1:0] req_wr_addr,
  input  logic [NREQ*CFG_DWIDTH-1:0] req_wr_data,
  input  logic [NREQ-1:0]            req_rd_en,
  input  logic [NREQ*CFG_AWIDTH-1:0] req_rd_addr,
`ifdef CFG_ARB_LOCK_EN
  input  logic [NREQ-1:0]            req_lock,
`endif
  output logic [NREQ-1:0]            req_gnt,
  output logic [NREQ-1:0]            req_rd_valid,
  output logic [CFG_DWIDTH-1:0]      req_rd_data,
  output logic                       cfg_wr_en,
  output logic [CFG_AWIDTH-1:0]      cfg_wr_addr,
  output logic [CFG_DWIDTH-1:0]      cfg_wr_data,
  output logic                       cfg_rd_en,
  output logic [CFG_AWIDTH-1:0]      cfg_rd_addr,
  input  logic [CFG_DWIDTH-1:0]      cfg_rd_data
);

  localparam int TW = idx_w(NREQ);

  logic [CFG_AWIDTH-1:0] wa [NREQ];
  logic [CFG_AWIDTH-1:0] ra [NREQ];
  logic [CFG_DWIDTH-1:0] wd [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      wa[i] = req_wr_addr[i*CFG_AWIDTH +: CFG_AWIDTH];
      ra[i] = req_rd_addr[i*CFG_AWIDTH +: CFG_AWIDTH];
      wd[i] = req_wr_data[i*CFG_DWIDTH +: CFG_DWIDTH];
    end
  end

  logic [NREQ-1:0] active;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] gnt;
  logic [TW-1:0]   gidx;
  logic            any;

  assign active = (req_wr_en | req_rd_en) & {NREQ{~rst}};

`ifdef CFG_ARB_LOCK_EN
  logic [TW-1:0] last_q;
  logic          last_vld_q;
  logic          lock_on;

  // A locked owner is the only eligible requester.
  assign lock_on = last_vld_q & req_lock[last_q];
  assign elig    = lock_on ? (active & (NREQ'(1) << last_q))
                           : active;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else if (any) begin
      last_q     <= gidx;
      last_vld_q <= 1'b1;
    end
  end
`else
  assign elig = active;
`endif

  logic [TW-1:0] ptr_q, ptr_d;

  arb_rr #(
    .N  (NREQ),
    .TW (TW)
  ) u_arb (
    .req_i (elig),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gidx),
    .any_o (any)
  );

  assign req_gnt = gnt;

  op_e op;

  // Write wins when both are held; the read waits for its own grant.
  always_comb begin
    op = OP_NONE;
    if (any) op = req_wr_en[gidx] ? OP_WR : OP_RD;
  end

  logic                  wen_q, wen_d;
  logic                  ren_q, ren_d;
  logic [CFG_AWIDTH-1:0] wa_q, wa_d;
  logic [CFG_AWIDTH-1:0] ra_q, ra_d;
  logic [CFG_DWIDTH-1:0] wd_q, wd_d;
  logic [RD_LATENCY:0]   vld_q, vld_d;
  logic [TW-1:0]         tag_q [RD_LATENCY+1];

  always_comb begin
    ptr_d = ptr_q;
    wen_d = 1'b0;
    ren_d = 1'b0;
    wa_d  = wa_q;
    wd_d  = wd_q;
    ra_d  = ra_q;
    unique case (op)
      OP_WR: begin
        wen_d = 1'b1;
        wa_d  = wa[gidx];
        wd_d  = wd[gidx];
      end
      OP_RD: begin
        ren_d = 1'b1;
        ra_d  = ra[gidx];
      end
      default: ;
    endcase
    if (any) begin
      ptr_d = (gidx == TW'(NREQ - 1)) ? '0 : gidx + 1'b1;
    end
  end

  assign vld_d = {vld_q[RD_LATENCY-1:0], op == OP_RD};

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      wen_q <= 1'b0;
      ren_q <= 1'b0;
      wa_q  <= '0;
      wd_q  <= '0;
      ra_q  <= '0;
      vld_q <= '0;
      for (int s = 0; s <= RD_LATENCY; s++) tag_q[s] <= '0;
    end else begin
      ptr_q    <= ptr_d;
      wen_q    <= wen_d;
      ren_q    <= ren_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
      ra_q     <= ra_d;
      vld_q    <= vld_d;
      tag_q[0] <= gidx;
      for (int s = 1; s <= RD_LATENCY; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  assign cfg_wr_en   = wen_q;
  assign cfg_wr_addr = wa_q;
  assign cfg_wr_data = wd_q;
  assign cfg_rd_en   = ren_q;
  assign cfg_rd_addr = ra_q;

  assign req_rd_valid = vld_q[RD_LATENCY]
                      ? (NREQ'(1) << tag_q[RD_LATENCY]) : '0;
  assign req_rd_data  = vld_q[RD_LATENCY] ? cfg_rd_data : '0;

endmodule
